// File: rtl/spi_master_phy_pkg.sv
// Shared definitions for the SPI master/slave link: frame layout, op codes,
// FSM state encoding and a frame packing helper.
package spi_defs;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam int SPI_ADDR_W     = 7;
  localparam int SPI_DATA_W     = 8;
  localparam int SPI_FRAME_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Frame is {op, addr, data}; the data byte is zeroed on reads.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_pack_frame(
    input logic                  rd,
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] wdata
  );
    logic [SPI_DATA_W-1:0] data;
    data = (rd == OP_READ) ? '0 : wdata;
    return {rd, addr, data};
  endfunction

endpackage

// File: rtl/spi_master_phy_sck_gen.sv
// SCK generator: divides clk into CLK_DIV-cycle low/high half-periods while
// enabled, and flags the last clk of each high phase.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sck,
  output logic fall_stb,
  output logic rise_end_stb
);

  logic [7:0] div_cnt;
  logic       div_last;

  assign div_last = (div_cnt == 8'(CLK_DIV - 1));

  // Half-period counter and sck register; parked low with a cleared count
  // whenever disabled so each frame starts on a full low phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (div_last) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // The last high clk is also the clk on whose edge sck falls, so the two
  // strobes coincide: one is used for sampling, the other for advancing mosi.
  assign rise_end_stb = en & sck & div_last;
  assign fall_stb     = en & sck & div_last;

endmodule

// File: rtl/spi_master_phy.sv
// SPI master PHY: turns one register-access command into a 16-bit
// {op, addr[6:0], data[7:0]} frame on csn/sck/mosi and captures the read byte
// from miso. All pin outputs are registered.
module spi_master_phy
  import spi_defs::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd,
  input  logic [SPI_ADDR_W-1:0] cmd_addr,
  input  logic [SPI_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [SPI_DATA_W-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_csn,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  spi_state_e                  state_q, state_d;
  logic [15:0]                 tmr_q;
  logic                        tmr_last;
  logic [SPI_FRAME_BITS-1:0]   shreg_q;
  logic [3:0]                  bit_cnt_q;
  logic [SPI_DATA_W-1:0]       rdata_q;
  logic                        accept;
  logic                        enter_gap;
  logic                        sck_en;
  logic                        fall_stb;
  logic                        rise_end_stb;

  assign accept    = cmd_valid & cmd_ready;
  assign sck_en    = (state_q == ST_SHIFT);
  assign enter_gap = (state_d == ST_GAP) && (state_q != ST_GAP);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (sck_en),
    .sck          (spi_sck),
    .fall_stb     (fall_stb),
    .rise_end_stb (rise_end_stb)
  );

  // Terminal count of the timed states (setup, hold, inter-frame gap).
  always_comb begin
    tmr_last = 1'b0;
    case (state_q)
      ST_SETUP: tmr_last = (tmr_q == 16'(CS_SETUP - 1));
      ST_HOLD:  tmr_last = (tmr_q == 16'(CS_HOLD - 1));
      ST_GAP:   tmr_last = (tmr_q == 16'(CS_IDLE - 1));
      default:  tmr_last = 1'b0;
    endcase
  end

  // Next-state logic; bit 15's falling edge leads to HOLD, never back to bit 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (tmr_last) state_d = ST_SHIFT;
      ST_SHIFT: if (fall_stb && (bit_cnt_q == 4'd15)) state_d = ST_HOLD;
      ST_HOLD:  if (tmr_last) state_d = ST_GAP;
      ST_GAP:   if (tmr_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // State timer: restarts on every state change, idles at zero otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q <= '0;
    end else if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_SHIFT)) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 16'd1;
    end
  end

  // Shift register, bit counter and mosi: load on accept, advance on sck fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      spi_mosi  <= 1'b0;
    end else begin
      if (accept) begin
        shreg_q   <= spi_pack_frame(cmd_rd, cmd_addr, cmd_wdata);
        bit_cnt_q <= '0;
        spi_mosi  <= cmd_rd;
      end else if (sck_en && fall_stb && (bit_cnt_q != 4'd15)) begin
        shreg_q   <= {shreg_q[SPI_FRAME_BITS-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 4'd1;
        spi_mosi  <= shreg_q[SPI_FRAME_BITS-2];
      end
      if (enter_gap) begin
        spi_mosi <= 1'b0;
      end
    end
  end

  // Read capture: miso sampled at the end of each data-phase high phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (accept) begin
      rdata_q <= '0;
    end else if (sck_en && rise_end_stb && bit_cnt_q[3]) begin
      rdata_q <= {rdata_q[SPI_DATA_W-2:0], spi_miso};
    end
  end

  // Registered handshake, response and chip-select outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      spi_csn   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cmd_ready <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
      spi_csn   <= !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
      rsp_valid <= enter_gap;
      if (enter_gap) begin
        rsp_rdata <= rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_phy.sv
// Bench for spi_master_phy: a default-parameter instance and a CLK_DIV=2
// instance share the command inputs (gated by sel); a bus monitor acts as the
// SPI slave, decodes frames and checks them against a scoreboard.
module tb_spi_master_phy;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_rd, sel;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       spi_miso;
  logic       v0, v1;

  logic       cmd_ready0, rsp_valid0, busy0, csn0, sck0, mosi0;
  logic       cmd_ready1, rsp_valid1, busy1, csn1, sck1, mosi1;
  logic [7:0] rsp_rdata0, rsp_rdata1;

  logic       m_ready, m_rsp_valid, m_busy, m_csn, m_sck, m_mosi;
  logic [7:0] m_rsp_rdata;

  int          checks = 0, failures = 0;
  logic [15:0] exp_frame[$];
  logic [7:0]  exp_rdata[$];
  logic [7:0]  slv_tx = 8'h00;

  int          acc_cnt = 0, rsp_cnt = 0, wr_cnt = 0, frame_cnt = 0;
  logic [14:0] last_wr = '0;
  logic [7:0]  last_rsp = '0;
  int          mon_n = 0;

  always #5 clk = ~clk;

  assign v0 = cmd_valid & ~sel;
  assign v1 = cmd_valid & sel;

  assign m_ready     = sel ? cmd_ready1 : cmd_ready0;
  assign m_rsp_valid = sel ? rsp_valid1 : rsp_valid0;
  assign m_rsp_rdata = sel ? rsp_rdata1 : rsp_rdata0;
  assign m_busy      = sel ? busy1      : busy0;
  assign m_csn       = sel ? csn1       : csn0;
  assign m_sck       = sel ? sck1       : sck0;
  assign m_mosi      = sel ? mosi1      : mosi0;

  spi_master_phy #(
    .CLK_DIV (4), .CS_SETUP (CS_SETUP), .CS_HOLD (CS_HOLD), .CS_IDLE (CS_IDLE)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .cmd_valid (v0), .cmd_ready (cmd_ready0), .cmd_rd (cmd_rd),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid0), .rsp_rdata (rsp_rdata0), .busy (busy0),
    .spi_csn (csn0), .spi_sck (sck0), .spi_mosi (mosi0), .spi_miso (spi_miso)
  );

  spi_master_phy #(
    .CLK_DIV (2), .CS_SETUP (CS_SETUP), .CS_HOLD (CS_HOLD), .CS_IDLE (CS_IDLE)
  ) dut2 (
    .clk (clk), .reset_n (reset_n),
    .cmd_valid (v1), .cmd_ready (cmd_ready1), .cmd_rd (cmd_rd),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid1), .rsp_rdata (rsp_rdata1), .busy (busy1),
    .spi_csn (csn1), .spi_sck (sck1), .spi_mosi (mosi1), .spi_miso (spi_miso)
  );

  // Slave model and scoreboard consumer, sampled on the falling clk edge.
  initial begin : monitor
    logic        p_csn, p_sck, p_mosi, p_rsp;
    logic        have_prev, mosi_bad, per_bad, first_bad;
    logic [15:0] rx, ef;
    logic [7:0]  er;
    int          cyc, div, low_len, high_len, fall_cyc, last_rise;
    p_csn = 1'b1; p_sck = 1'b0; p_mosi = 1'b0; p_rsp = 1'b0;
    have_prev = 1'b0; mosi_bad = 1'b0; per_bad = 1'b0; first_bad = 1'b0;
    rx = '0; cyc = 0; low_len = 0; high_len = 0; fall_cyc = 0; last_rise = 0;
    spi_miso = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      div = sel ? 2 : 4;
      if (!reset_n) begin
        mon_n = 0; have_prev = 1'b0; high_len = 0;
        p_csn = 1'b1; p_sck = 1'b0; p_mosi = 1'b0; p_rsp = 1'b0;
      end else begin
        if (cmd_valid && m_ready) acc_cnt++;
        if (p_csn && !m_csn) begin
          if (have_prev) begin
            checks++;
            if (high_len < CS_IDLE) begin
              failures++;
              $display("FAIL csn_gap got=%0d want>=%0d", high_len, CS_IDLE);
            end
          end
          mon_n = 0; low_len = 0; rx = '0; fall_cyc = cyc;
          mosi_bad = 1'b0; per_bad = 1'b0; first_bad = 1'b0;
        end
        if (!m_csn) begin
          low_len++;
          if (!p_sck && m_sck) begin
            mon_n++;
            rx = {rx[14:0], m_mosi};
            if (mon_n == 1) begin
              if (cyc - fall_cyc != CS_SETUP + div) first_bad = 1'b1;
            end else if (cyc - last_rise != 2 * div) begin
              per_bad = 1'b1;
            end
            last_rise = cyc;
            if (mon_n >= 9 && mon_n <= 16) spi_miso = slv_tx[16 - mon_n];
          end
          if (!p_csn && (m_mosi !== p_mosi) && !(p_sck && !m_sck)) mosi_bad = 1'b1;
        end
        if (!p_csn && m_csn) begin
          frame_cnt++;
          checks++;
          if (exp_frame.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected got=%h", rx);
          end else begin
            ef = exp_frame.pop_front();
            if (rx !== ef || mon_n != 16) begin
              failures++;
              $display("FAIL frame_bits got=%h bits=%0d want=%h bits=16", rx, mon_n, ef);
            end
          end
          checks++;
          if (low_len != CS_SETUP + 32 * div + CS_HOLD) begin
            failures++;
            $display("FAIL csn_low got=%0d want=%0d", low_len, CS_SETUP + 32 * div + CS_HOLD);
          end
          checks++;
          if (first_bad || per_bad) begin
            failures++;
            $display("FAIL sck_timing got first_bad=%0b per_bad=%0b want 0 0", first_bad, per_bad);
          end
          checks++;
          if (mosi_bad) begin
            failures++;
            $display("FAIL mosi_stable got=1 want=0");
          end
          if (mon_n == 16 && rx[15] == 1'b0) begin
            wr_cnt++;
            last_wr = rx[14:0];
          end
          have_prev = 1'b1;
          high_len = 0;
        end
        if (m_csn) high_len++;
        if (m_rsp_valid) begin
          checks++;
          rsp_cnt++;
          last_rsp = m_rsp_rdata;
          if (p_rsp) begin
            failures++;
            $display("FAIL rsp_pulse got=2+ clks want=1");
          end else if (exp_rdata.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected got=%h", m_rsp_rdata);
          end else begin
            er = exp_rdata.pop_front();
            if (m_rsp_rdata !== er) begin
              failures++;
              $display("FAIL rsp_rdata got=%h want=%h", m_rsp_rdata, er);
            end
          end
        end
        p_csn = m_csn; p_sck = m_sck; p_mosi = m_mosi; p_rsp = m_rsp_valid;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input logic rd, input logic [6:0] addr, input logic [7:0] wd,
                       input logic [7:0] tx);
    int t = 0;
    while (!m_ready && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (!m_ready) begin
      checks++; failures++;
      $display("FAIL issue_ready got=0 want=1");
    end
    slv_tx = tx;
    exp_frame.push_back({rd, addr, rd ? 8'h00 : wd});
    exp_rdata.push_back(tx);
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = addr; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((m_busy || !m_ready || exp_frame.size() != 0 || exp_rdata.size() != 0) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t >= 3000) begin
      failures++;
      $display("FAIL idle_timeout got busy=%0b pend=%0d want idle", m_busy, exp_frame.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({csn0, sck0, mosi0, rsp_valid0, busy0, rsp_rdata0} !== {5'b10000, 8'h00}) begin
      failures++;
      $display("FAIL reset_dut got=%b want=%b", {csn0, sck0, mosi0, rsp_valid0, busy0, rsp_rdata0},
               {5'b10000, 8'h00});
    end
    checks++;
    if ({csn1, sck1, mosi1, rsp_valid1, busy1, rsp_rdata1} !== {5'b10000, 8'h00}) begin
      failures++;
      $display("FAIL reset_dut2 got=%b want=%b", {csn1, sck1, mosi1, rsp_valid1, busy1, rsp_rdata1},
               {5'b10000, 8'h00});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready0, cmd_ready1, busy0} !== 3'b110) begin
      failures++;
      $display("FAIL ready_after_reset got=%b want=110", {cmd_ready0, cmd_ready1, busy0});
    end
  endtask

  task automatic test_write();
    int wr0 = wr_cnt, rsp0 = rsp_cnt, lat = 1;
    issue(1'b0, 7'h15, 8'hA5, 8'h5A);
    checks++;
    if ({m_busy, m_ready, m_csn} !== 3'b100) begin
      failures++;
      $display("FAIL accept_state got=%b want=100", {m_busy, m_ready, m_csn});
    end
    while (!m_rsp_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 133) begin
      failures++;
      $display("FAIL write_latency got=%0d want=133", lat);
    end
    wait_idle();
    checks++;
    if (wr_cnt != wr0 + 1 || last_wr !== 15'h15A5 || rsp_cnt != rsp0 + 1) begin
      failures++;
      $display("FAIL write_result got wr=%0d/%h rsp=%0d want wr=%0d/15a5 rsp=%0d",
               wr_cnt - wr0, last_wr, rsp_cnt - rsp0, 1, 1);
    end
  endtask

  task automatic test_read();
    int wr0 = wr_cnt, rsp0 = rsp_cnt;
    issue(1'b1, 7'h7F, 8'hEE, 8'h3C);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt != wr0 || rsp_cnt != rsp0 + 1 || last_rsp !== 8'h3C || m_rsp_rdata !== 8'h3C) begin
      failures++;
      $display("FAIL read_result got wr=%0d rsp=%0d data=%h held=%h want wr=0 rsp=1 data=3c held=3c",
               wr_cnt - wr0, rsp_cnt - rsp0, last_rsp, m_rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int acc0 = acc_cnt, fr0 = frame_cnt, wr0 = wr_cnt, t = 0;
    slv_tx = 8'h99;
    for (int i = 0; i < 3; i++) begin
      exp_frame.push_back(16'h2AC3);
      exp_rdata.push_back(8'h99);
    end
    cmd_rd = 1'b0; cmd_addr = 7'h2A; cmd_wdata = 8'hC3; cmd_valid = 1'b1;
    while (acc_cnt - acc0 < 3 && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    cmd_valid = 1'b0;
    wait_idle();
    checks++;
    if (acc_cnt - acc0 != 3 || frame_cnt - fr0 != 3 || wr_cnt - wr0 != 3) begin
      failures++;
      $display("FAIL back_to_back got acc=%0d frames=%0d writes=%0d want 3 3 3",
               acc_cnt - acc0, frame_cnt - fr0, wr_cnt - wr0);
    end
  endtask

  task automatic test_reset_mid();
    int rsp0 = rsp_cnt, t = 0;
    issue(1'b0, 7'h33, 8'h11, 8'h00);
    while (!(mon_n == 6 && !m_csn) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m_csn, m_sck, m_busy, m_rsp_valid} !== 4'b1000 || t >= 500) begin
      failures++;
      $display("FAIL reset_mid got csn/sck/busy/rsp=%b reached=%0d want 1000", {m_csn, m_sck, m_busy,
               m_rsp_valid}, t < 500);
    end
    exp_frame.delete();
    exp_rdata.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (rsp_cnt != rsp0) begin
      failures++;
      $display("FAIL reset_mid_rsp got=%0d want=0", rsp_cnt - rsp0);
    end
    issue(1'b0, 7'h01, 8'hFF, 8'h81);
    wait_idle();
    checks++;
    if (last_wr !== 15'h01FF || rsp_cnt != rsp0 + 1) begin
      failures++;
      $display("FAIL post_reset_write got=%h rsp=%0d want=01ff rsp=1", last_wr, rsp_cnt - rsp0);
    end
  endtask

  task automatic test_clkdiv2();
    sel = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 7'h0A, 8'h55, 8'h00);
    wait_idle();
    checks++;
    if (last_wr !== {7'h0A, 8'h55}) begin
      failures++;
      $display("FAIL div2_write1 got=%h want=%h", last_wr, {7'h0A, 8'h55});
    end
    issue(1'b1, 7'h0A, 8'h00, 8'hAA);
    wait_idle();
    checks++;
    if (last_rsp !== 8'hAA) begin
      failures++;
      $display("FAIL div2_read1 got=%h want=aa", last_rsp);
    end
    issue(1'b0, 7'h0B, 8'hAA, 8'h00);
    wait_idle();
    checks++;
    if (last_wr !== {7'h0B, 8'hAA}) begin
      failures++;
      $display("FAIL div2_write2 got=%h want=%h", last_wr, {7'h0B, 8'hAA});
    end
    issue(1'b1, 7'h0B, 8'h00, 8'h55);
    wait_idle();
    checks++;
    if (last_rsp !== 8'h55) begin
      failures++;
      $display("FAIL div2_read2 got=%h want=55", last_rsp);
    end
    sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int acc0 = acc_cnt;
    issue(1'b0, 7'h22, 8'h5C, 8'h00);
    for (int i = 0; i < 60; i++) begin
      cmd_valid = 1'b1;
      cmd_rd    = 1'($urandom_range(0, 1));
      cmd_addr  = 7'($urandom);
      cmd_wdata = 8'($urandom);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_idle();
    checks++;
    if (acc_cnt - acc0 != 1 || last_wr !== {7'h22, 8'h5C}) begin
      failures++;
      $display("FAIL busy_ignore got acc=%0d wr=%h want acc=1 wr=%h", acc_cnt - acc0, last_wr,
               {7'h22, 8'h5C});
    end
  endtask

  initial begin : main
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv2();
    test_busy_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
